// File: rtl/dm_arbiter_8085_if.sv
// Bundled request/response/memory signals for the 8085 data-memory arbiter.
// slave = arbiter side, master = requesters plus DM side.
interface dm_arbiter_8085_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;

    logic          ext_req;
    logic          ext_we;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata;
    logic          ext_gnt;
    logic          ext_rvalid;
    logic [DW-1:0] ext_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        input  mem_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        output ext_gnt, ext_rvalid, ext_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ext_req, ext_we, ext_addr, ext_wdata,
        output mem_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        input  ext_gnt, ext_rvalid, ext_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/dm_arbiter_8085.sv
// CPU/EXT arbiter for the 8085 data memory: IDLE -> ACCESS -> RESP per access.
// Define DM_ARB_RR_EN for round-robin contention instead of CPU priority + wait guard.
module dm_arbiter_8085 #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    dm_arbiter_8085_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } acc_t;

    state_t state, state_n;
    logic   owner_ext;
    logic   any_req, arb_edge, ext_win;
    acc_t   cpu_acc, ext_acc, win_acc;

    assign cpu_acc = {bus.cpu_we, bus.cpu_addr, bus.cpu_wdata};
    assign ext_acc = {bus.ext_we, bus.ext_addr, bus.ext_wdata};
    assign any_req = bus.cpu_req | bus.ext_req;
    assign win_acc = ext_win ? ext_acc : cpu_acc;

`ifdef DM_ARB_RR_EN
    logic last_ext;  // 1 when EXT won the previous arbitration
    assign ext_win = bus.ext_req & (~bus.cpu_req | ~last_ext);
`else
    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);
    logic [3:0] wait_cnt;
    assign ext_win = bus.ext_req & (~bus.cpu_req | (wait_cnt == WAIT_LIM));
`endif

    always_comb begin
        state_n  = state;
        arb_edge = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_n  = ACCESS;
                    arb_edge = 1'b1;
                end
            end
            ACCESS: state_n = RESP;
            RESP: begin
                if (any_req) begin
                    state_n  = ACCESS;
                    arb_edge = 1'b1;
                end else begin
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.cpu_gnt    <= 1'b0;
            bus.ext_gnt    <= 1'b0;
            bus.cpu_rvalid <= 1'b0;
            bus.ext_rvalid <= 1'b0;
            bus.cpu_rdata  <= '0;
            bus.ext_rdata  <= '0;
            bus.mem_en     <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.busy       <= 1'b0;
            owner_ext      <= 1'b0;
`ifdef DM_ARB_RR_EN
            last_ext       <= 1'b1;
`else
            wait_cnt       <= '0;
`endif
        end else begin
            bus.busy       <= (state_n != IDLE);
            bus.cpu_gnt    <= 1'b0;
            bus.ext_gnt    <= 1'b0;
            bus.cpu_rvalid <= 1'b0;
            bus.ext_rvalid <= 1'b0;
            bus.mem_en     <= 1'b0;
            if (arb_edge) begin
                bus.mem_en  <= 1'b1;
                bus.cpu_gnt <= ~ext_win;
                bus.ext_gnt <= ext_win;
                owner_ext   <= ext_win;
                // Latched here so requesters may change inputs during ACCESS
                {bus.mem_we, bus.mem_addr, bus.mem_wdata} <= win_acc;
`ifdef DM_ARB_RR_EN
                last_ext <= ext_win;
`else
                if (ext_win)
                    wait_cnt <= '0;
                else if (bus.ext_req && wait_cnt != WAIT_LIM)
                    wait_cnt <= wait_cnt + 4'd1;
`endif
            end
            if (state == ACCESS) begin
                if (owner_ext) begin
                    bus.ext_rvalid <= 1'b1;
                    if (!bus.mem_we) bus.ext_rdata <= bus.mem_rdata;
                end else begin
                    bus.cpu_rvalid <= 1'b1;
                    if (!bus.mem_we) bus.cpu_rdata <= bus.mem_rdata;
                end
            end
        end
    end
endmodule
